pack_tx: RTL and testbench
==========================

# pack_tx

UART transmitter that serialises one 13-bit value as two back-to-back 8N1 frames: low byte first, then high byte. It is the sending end of the two-byte packing scheme used by the fan controller's serial link. A peer receiver reassembles bits [12:0] from byte0 = data[7:0] and byte1[4:0] = data[12:8]. The block sits between the temperature/speed logic, which produces values through a valid/ready handshake, and the board TX pin.

## Interface
- `UART_BPS`, default 115200: serial baud rate.
- `CLK_FREQ`, default 50_000_000: sys_clk frequency in Hz.
- `sys_clk`, in, 1: system clock, 50 MHz.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low; clock sys_clk.
- `in_data`, in, 13: value to transmit.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: the block can accept a value.
- `busy`, out, 1: a two-byte packet is in progress.
- `tx_done`, out, 1: one-cycle pulse when the packet is complete.
- `tx`, out, 1: serial output; idles high; registered.

## Operation
- `BAUD_CNT_MAX = CLK_FREQ/UART_BPS`, using integer division. With the defaults this is 434.
- Each bit lasts exactly `BAUD_CNT_MAX` sys_clk cycles.
- The baud counter is 13 bits wide. It counts 0 to `BAUD_CNT_MAX-1` while busy and is held at 0 when idle.
- Accept:
  - A value is accepted on a clock edge where `in_valid && in_ready`.
  - `in_data` is latched into an internal 13-bit shadow register.
  - Changes to `in_data` after acceptance are ignored.
- Frame format:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - No parity.
- Byte content:
  - byte0 = shadow[7:0].
  - byte1 = {tag[2:0], shadow[12:8]}; see Configuration for `tag`.
- State machine, with a `byte_sel` flag (0 or 1) and a bit index `bit_idx` (0 to 7):
  - IDLE: `tx`=1, `in_ready`=1, `busy`=0. On accept: go to START, `byte_sel`=0.
  - START: `tx`=0 for one bit time, then go to DATA with `bit_idx`=0.
  - DATA: `tx` = current byte[`bit_idx`] for one bit time. After `bit_idx`=7, go to STOP.
  - STOP: `tx`=1 for one bit time.
    - If `byte_sel`=0: set `byte_sel`=1 and go to START. There is no idle gap between the bytes.
    - If `byte_sel`=1: pulse `tx_done` and go to IDLE.
- `in_ready` = (state == IDLE). `busy` = !`in_ready`.
- Reset values: `tx`=1, `in_ready`=1, `busy`=0, `tx_done`=0, state=IDLE, counters 0, shadow 0.
- Reset mid-packet aborts immediately: `tx` goes high asynchronously and the partial frame is discarded.
- `in_valid` while busy: nothing is accepted. The upstream must hold the value; no data is lost or queued.

## Timing
- Accept edge = cycle 0. `tx` falls at cycle 1, which is the first cycle of the byte0 start bit.
- Byte0 occupies cycles 1 to 4340. Byte1 occupies cycles 4341 to 8680. Both figures assume the 434-cycle default bit time.
- `tx_done` is high for exactly one cycle, at cycle 8681.
- `in_ready` returns to 1 in that same cycle 8681. A new value offered with `in_valid` held high is accepted on that edge, so its start bit begins at cycle 8682.
- Minimum packet-to-packet period is 20 bit times plus 1 cycle.
- `tx` transitions occur only on baud counter wrap boundaries. There are no glitches, because `tx` comes directly from a flop.
- Rounding error of the bit time stays below 0.05 % for the defaults.

## Configuration
- `PACK_TX_TAG_EN`:
  - Defined: byte1[7:5] = 3'b101, a packet marker the receiver can check. It is ignored by receivers that keep only bits [12:0].
  - Undefined: byte1[7:5] = 3'b000.
  - Timing and handshake are identical in both builds.

## Test plan
- Reset release, then 1000 idle cycles → `tx`=1, `in_ready`=1, `busy`=0, `tx_done` never pulses.
- Send 13'h0A5C with the tag build off:
  - Sampling mid-bit gives byte0 0x5C, then byte1 0x0A, each with start 0 and stop 1.
  - `tx` falls at cycle 1.
  - `tx_done` pulses at cycle 8681.
- Send 13'h0A5C with `PACK_TX_TAG_EN` defined → byte1 = 0xAA; byte0 is unchanged at 0x5C.
- Extreme values:
  - Send 13'h1FFF → bytes 0xFF, 0x1F.
  - Send 13'h0000 → bytes 0x00, 0x00.
  - A loopback into the receiver recovers each value exactly.
- Back-to-back and busy behaviour:
  - Hold `in_valid` high with value 13'h0123, then change `in_data` to 13'h1456 while busy.
  - Required: the first packet carries 0x23, 0x01. The second packet, carrying 0x56, 0x14, is accepted at cycle 8681 with no extra gap.
- Assert `sys_rst_n`=0 during the byte1 data bits → `tx`=1 immediately, `in_ready`=1 after release, and no `tx_done` pulse.

Source files
------------

// File: rtl/pack_tx.sv
// pack_tx: UART transmitter that sends one 13-bit value as two back-to-back 8N1 frames,
// low byte first (data[7:0]), then high byte ({tag, data[12:8]}).
//
// Parameters:
//   UART_BPS  - serial baud rate (default 115200)
//   CLK_FREQ  - sys_clk frequency in Hz (default 50_000_000)
// Ports:
//   sys_clk   - system clock
//   sys_rst_n - asynchronous active-low reset
//   in_data   - 13-bit value to transmit, latched on accept
//   in_valid  - in_data is valid
//   in_ready  - block is idle and can accept a value
//   busy      - a two-byte packet is in progress
//   tx_done   - one-cycle pulse when the packet completes
//   tx        - registered serial output, idles high
// Build option:
//   PACK_TX_TAG_EN - when defined, byte1[7:5] carries the packet marker 3'b101,
//                    otherwise 3'b000.

module pack_tx #(
   parameter int unsigned UART_BPS = 115200,
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [12:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        busy,
   output logic        tx_done,
   output logic        tx
);

   localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
   localparam logic [12:0] BaudLast     = 13'(BAUD_CNT_MAX - 1);

`ifdef PACK_TX_TAG_EN
   localparam logic [2:0] Tag = 3'b101;
`else
   localparam logic [2:0] Tag = 3'b000;
`endif

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e      state_q, state_d;
   logic [12:0] baud_cnt_q, baud_cnt_d;
   logic [12:0] shadow_q, shadow_d;
   logic        byte_sel_q, byte_sel_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        tx_q, tx_d;
   logic        tx_done_q, tx_done_d;

   logic [7:0]  cur_byte;
   logic [2:0]  bit_nxt;
   logic        baud_wrap;

   always_comb begin
      cur_byte  = byte_sel_q ? {Tag, shadow_q[12:8]} : shadow_q[7:0];
      bit_nxt   = bit_idx_q + 3'd1;
      baud_wrap = (baud_cnt_q == BaudLast);
   end

   // tx is loaded one bit ahead at each baud wrap so the pin comes straight from a flop.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      shadow_d   = shadow_q;
      byte_sel_d = byte_sel_q;
      bit_idx_d  = bit_idx_q;
      tx_d       = tx_q;
      tx_done_d  = 1'b0;

      if (state_q != StIdle) begin
         baud_cnt_d = baud_wrap ? 13'd0 : baud_cnt_q + 13'd1;
      end

      case (state_q)
         StIdle: begin
            baud_cnt_d = 13'd0;
            tx_d       = 1'b1;
            if (in_valid) begin
               shadow_d   = in_data;
               byte_sel_d = 1'b0;
               state_d    = StStart;
               tx_d       = 1'b0;
            end
         end
         StStart: begin
            if (baud_wrap) begin
               state_d   = StData;
               bit_idx_d = 3'd0;
               tx_d      = cur_byte[0];
            end
         end
         StData: begin
            if (baud_wrap) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_nxt;
                  tx_d      = cur_byte[bit_nxt];
               end
            end
         end
         StStop: begin
            if (baud_wrap) begin
               if (!byte_sel_q) begin
                  // Second frame starts immediately, no idle gap.
                  byte_sel_d = 1'b1;
                  state_d    = StStart;
                  tx_d       = 1'b0;
               end else begin
                  state_d   = StIdle;
                  tx_done_d = 1'b1;
                  tx_d      = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= StIdle;
         baud_cnt_q <= 13'd0;
         shadow_q   <= 13'd0;
         byte_sel_q <= 1'b0;
         bit_idx_q  <= 3'd0;
         tx_q       <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         shadow_q   <= shadow_d;
         byte_sel_q <= byte_sel_d;
         bit_idx_q  <= bit_idx_d;
         tx_q       <= tx_d;
         tx_done_q  <= tx_done_d;
      end
   end

   assign in_ready = (state_q == StIdle);
   assign busy     = ~in_ready;
   assign tx_done  = tx_done_q;
   assign tx       = tx_q;

endmodule

// File: tb/tb_pack_tx.sv
// tb_pack_tx: directed self-checking bench for pack_tx at the default 434-cycle bit time.
// A packet-level model predicts tx/in_ready/busy/tx_done every cycle; directed packets are
// also decoded mid-bit and compared against hand-computed bytes and cycle numbers.

`timescale 1ns/1ps

module tb_pack_tx;

   localparam int BIT_T = 434;
   localparam int PKT_T = 20 * BIT_T + 1;

`ifdef PACK_TX_TAG_EN
   localparam logic [7:0] TAG_BITS = 8'hA0;
`else
   localparam logic [7:0] TAG_BITS = 8'h00;
`endif

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [12:0] in_data   = 13'd0;
   logic        in_valid  = 1'b0;
   logic        in_ready;
   logic        busy;
   logic        tx_done;
   logic        tx;

   int checks = 0;
   int errors = 0;

   always #10 sys_clk = ~sys_clk;

   pack_tx dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .busy      (busy),
      .tx_done   (tx_done),
      .tx        (tx)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Serial image of one packet, index 0 is the first bit on the wire.
   function automatic logic [19:0] frame_bits(input logic [12:0] d);
      logic [7:0] b0;
      logic [7:0] b1;
      b0 = d[7:0];
      b1 = {3'b000, d[12:8]} | TAG_BITS;
      return {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
   endfunction

   // Packet model: m_t counts cycles since the accept edge (1..PKT_T-1 while sending).
   bit          m_active = 1'b0;
   bit          m_done   = 1'b0;
   int          m_t      = 0;
   logic [19:0] m_bits   = '0;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_t      <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_active) begin
            m_t <= m_t + 1;
            if (m_t + 1 == PKT_T) begin
               m_active <= 1'b0;
               m_done   <= 1'b1;
            end
         end else if (in_valid) begin
            m_active <= 1'b1;
            m_t      <= 1;
            m_bits   <= frame_bits(in_data);
         end
      end
   end

   always @(negedge sys_clk) begin : cmp
      logic e_tx;
      e_tx = m_active ? m_bits[(m_t - 1) / BIT_T] : 1'b1;
      check("model_tx",    {31'd0, tx},       {31'd0, e_tx});
      check("model_ready", {31'd0, in_ready}, {31'd0, !m_active});
      check("model_busy",  {31'd0, busy},     {31'd0, m_active});
      check("model_done",  {31'd0, tx_done},  {31'd0, m_done});
   end

   // Called just after an accept edge; walks the packet and decodes it mid-bit.
   task automatic run_packet(input string name, input logic [7:0] eb0, input logic [7:0] eb1,
                             input int chg_cyc, input logic [12:0] chg_data, input bit drop);
      logic [19:0] bits;
      int          fall_cyc;
      int          done_cyc;
      int          done_cnt;
      bits     = '0;
      fall_cyc = -1;
      done_cyc = -1;
      done_cnt = 0;
      for (int c = 1; c <= PKT_T; c++) begin
         @(negedge sys_clk);
         if (c == 1 && drop) in_valid = 1'b0;
         if (c == chg_cyc) in_data = chg_data;
         if (fall_cyc < 0 && tx == 1'b0) fall_cyc = c;
         if (tx_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c < PKT_T && (c - 1) % BIT_T == BIT_T / 2) bits[(c - 1) / BIT_T] = tx;
      end
      check({name, "_fall_cyc"}, fall_cyc, 1);
      check({name, "_done_cyc"}, done_cyc, PKT_T);
      check({name, "_done_cnt"}, done_cnt, 1);
      check({name, "_start0"},   {31'd0, bits[0]},  32'd0);
      check({name, "_stop0"},    {31'd0, bits[9]},  32'd1);
      check({name, "_start1"},   {31'd0, bits[10]}, 32'd0);
      check({name, "_stop1"},    {31'd0, bits[19]}, 32'd1);
      check({name, "_byte0"},    {24'd0, bits[8:1]},   {24'd0, eb0});
      check({name, "_byte1"},    {24'd0, bits[18:11]}, {24'd0, eb1});
      check({name, "_ready_end"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic send(input logic [12:0] d, input logic [7:0] eb0, input logic [7:0] eb1,
                       input string name);
      @(negedge sys_clk);
      check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
      in_data  = d;
      in_valid = 1'b1;
      @(posedge sys_clk);
      run_packet(name, eb0, eb1, 0, 13'd0, 1'b1);
   endtask

   task automatic idle_watch(input int n, input string name);
      int done_cnt;
      int tx_low;
      int not_ready;
      done_cnt  = 0;
      tx_low    = 0;
      not_ready = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         if (tx_done) done_cnt++;
         if (tx !== 1'b1) tx_low++;
         if (in_ready !== 1'b1 || busy !== 1'b0) not_ready++;
      end
      check({name, "_done_pulses"}, done_cnt, 0);
      check({name, "_tx_low"},      tx_low, 0);
      check({name, "_not_ready"},   not_ready, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge sys_clk);
      check("reset_tx",    {31'd0, tx},       32'd1);
      check("reset_ready", {31'd0, in_ready}, 32'd1);
      check("reset_busy",  {31'd0, busy},     32'd0);
      check("reset_done",  {31'd0, tx_done},  32'd0);
      sys_rst_n = 1'b1;

      idle_watch(1000, "idle");

      send(13'h0A5C, 8'h5C, 8'h0A | TAG_BITS, "p0a5c");
      send(13'h1FFF, 8'hFF, 8'h1F | TAG_BITS, "p1fff");
      send(13'h0000, 8'h00, 8'h00 | TAG_BITS, "p0000");

      // Back-to-back: valid held high, data changed while busy.
      @(negedge sys_clk);
      in_data  = 13'h0123;
      in_valid = 1'b1;
      @(posedge sys_clk);
      run_packet("p0123", 8'h23, 8'h01 | TAG_BITS, 100, 13'h1456, 1'b0);
      @(posedge sys_clk);
      run_packet("p1456", 8'h56, 8'h14 | TAG_BITS, 0, 13'd0, 1'b1);

      // Reset during byte1 data bit 2 (a 0 bit of 0x0A / 0xAA).
      @(negedge sys_clk);
      in_data  = 13'h0A5C;
      in_valid = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      in_valid = 1'b0;
      repeat (13 * BIT_T) @(negedge sys_clk);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      check("pre_rst_tx",   {31'd0, tx},   32'd0);
      #3 sys_rst_n = 1'b0;
      #1;
      check("rst_tx_async",    {31'd0, tx},       32'd1);
      check("rst_ready_async", {31'd0, in_ready}, 32'd1);
      check("rst_busy_async",  {31'd0, busy},     32'd0);
      check("rst_done_async",  {31'd0, tx_done},  32'd0);
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      idle_watch(2000, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
